// File: rtl/kbd_spi_matrix.sv
// kbd_spi_matrix
// SPI slave receiving keyboard matrix frames from the USB/PS2/SEGA-GP
// controller and serving ZX port #FE half-row reads on KD.
// Frame layout (MSB first): byte0 = flags, bytes1..ROWS = rows 0..ROWS-1,
// and with KBD_SPI_JOY_EN defined, one trailing Kempston joystick byte.
// Optional feature macro: KBD_SPI_JOY_EN (adds JOY output, 80-bit frames).
// ROWS must not exceed 8, one row per A[15:8] line.

module kbd_spi_matrix #(
    parameter int          ROWS       = 8,
    parameter logic [7:0]  FLAG_RESET = 8'h00
) (
    input  logic       CLK_14MHZ,
    input  logic       RESET,
    input  logic       KBD_CS,
    input  logic       KBD_CLK,
    input  logic       KBD_DI,
    input  logic [7:0] A_HI,
    output logic [4:0] KD,
    output logic [7:0] FLAGS,
    output logic       FRAME_STB,
    output logic       FRAME_ERR
`ifdef KBD_SPI_JOY_EN
    ,
    output logic [4:0] JOY
`endif
);

`ifdef KBD_SPI_JOY_EN
    localparam int FRAME_BITS = (ROWS + 2) * 8;
`else
    localparam int FRAME_BITS = (ROWS + 1) * 8;
`endif
    localparam int                CNT_W     = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0]  FRAME_LEN = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_OVER
    } state_t;

    state_t state;
    state_t state_next;

    logic cs_s1, cs_s2, cs_s3;
    logic clk_s1, clk_s2, clk_s3;
    logic di_s1, di_s2;

    logic cs_fall, cs_rise, clk_rise;

    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shift_reg;

    logic cnt_clr;
    logic shift_en;
    logic do_commit;
    logic do_err;

    logic [ROWS-1:0][4:0] matrix;
    logic [4:0]           kd_acc;

    // Bring the asynchronous SPI pins into the CLK_14MHZ domain; the third
    // stage on CS and CLK gives a previous value for edge detection.
    always_ff @(posedge CLK_14MHZ) begin
        if (RESET) begin
            cs_s1  <= 1'b1;
            cs_s2  <= 1'b1;
            cs_s3  <= 1'b1;
            clk_s1 <= 1'b0;
            clk_s2 <= 1'b0;
            clk_s3 <= 1'b0;
            di_s1  <= 1'b1;
            di_s2  <= 1'b1;
        end else begin
            cs_s1  <= KBD_CS;
            cs_s2  <= cs_s1;
            cs_s3  <= cs_s2;
            clk_s1 <= KBD_CLK;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            di_s1  <= KBD_DI;
            di_s2  <= di_s1;
        end
    end

    assign cs_fall  =  cs_s3 & ~cs_s2;
    assign cs_rise  = ~cs_s3 &  cs_s2;
    assign clk_rise = ~clk_s3 & clk_s2;

    // Frame state register.
    always_ff @(posedge CLK_14MHZ) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; a CS edge always wins over a CLK edge
    // seen in the same cycle, and a CS fall anywhere restarts the frame.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        do_commit  = 1'b0;
        do_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next = ST_SHIFT;
                    cnt_clr    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cs_fall) begin
                    state_next = ST_SHIFT;
                    cnt_clr    = 1'b1;
                end else if (cs_rise) begin
                    state_next = ST_IDLE;
                    if (bit_cnt == FRAME_LEN) begin
                        do_commit = 1'b1;
                    end else begin
                        do_err = 1'b1;
                    end
                end else if (clk_rise) begin
                    if (bit_cnt == FRAME_LEN) begin
                        state_next = ST_OVER;
                    end else begin
                        shift_en = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (cs_fall) begin
                    state_next = ST_SHIFT;
                    cnt_clr    = 1'b1;
                end else if (cs_rise) begin
                    state_next = ST_IDLE;
                    do_err     = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bit counter and receive shift register (MSB first into the LSB end).
    always_ff @(posedge CLK_14MHZ) begin
        if (RESET) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (cnt_clr) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], di_s2};
            bit_cnt   <= bit_cnt + CNT_W'(1);
        end
    end

    // Committed state: the whole frame lands in one clock so the CPU never
    // sees a half-updated matrix; strobes are single-cycle pulses.
    always_ff @(posedge CLK_14MHZ) begin
        if (RESET) begin
            matrix    <= '1;
            FLAGS     <= FLAG_RESET;
            FRAME_STB <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef KBD_SPI_JOY_EN
            JOY       <= 5'b00000;
`endif
        end else begin
            FRAME_STB <= do_commit;
            FRAME_ERR <= do_err;
            if (do_commit) begin
                FLAGS <= shift_reg[FRAME_BITS-1 -: 8];
                for (int r = 0; r < ROWS; r++) begin
                    matrix[r] <= shift_reg[FRAME_BITS-16-8*r +: 5];
                end
`ifdef KBD_SPI_JOY_EN
                JOY <= shift_reg[4:0];
`endif
            end
        end
    end

    // Half-row read: AND together every row whose address line is low.
    always_comb begin
        kd_acc = 5'b11111;
        for (int r = 0; r < ROWS; r++) begin
            if (!A_HI[r]) begin
                kd_acc = kd_acc & matrix[r];
            end
        end
    end

    assign KD = kd_acc;

endmodule

// File: tb/tb_kbd_spi_matrix.sv
// Testbench for kbd_spi_matrix: directed frames from the test plan plus
// randomized valid/invalid frames, compared against a byte-level model.

module tb_kbd_spi_matrix;

`ifdef KBD_SPI_JOY_EN
    localparam int FB = 80;
`else
    localparam int FB = 72;
`endif

    logic       CLK_14MHZ;
    logic       RESET;
    logic       KBD_CS;
    logic       KBD_CLK;
    logic       KBD_DI;
    logic [7:0] A_HI;
    logic [4:0] KD;
    logic [7:0] FLAGS;
    logic       FRAME_STB;
    logic       FRAME_ERR;
`ifdef KBD_SPI_JOY_EN
    logic [4:0] JOY;
`endif

    int checks = 0;
    int errors = 0;

    int cyc      = 0;
    int stb_cnt  = 0;
    int err_cnt  = 0;
    int stb_cyc  = 0;

    logic [4:0] m_rows [8];
    logic [7:0] m_flags;
    logic [4:0] m_joy;

    kbd_spi_matrix dut (
        .CLK_14MHZ (CLK_14MHZ),
        .RESET     (RESET),
        .KBD_CS    (KBD_CS),
        .KBD_CLK   (KBD_CLK),
        .KBD_DI    (KBD_DI),
        .A_HI      (A_HI),
        .KD        (KD),
        .FLAGS     (FLAGS),
        .FRAME_STB (FRAME_STB),
        .FRAME_ERR (FRAME_ERR)
`ifdef KBD_SPI_JOY_EN
        ,
        .JOY       (JOY)
`endif
    );

    // 14 MHz-ish system clock
    initial begin
        CLK_14MHZ = 1'b0;
        forever #35 CLK_14MHZ = ~CLK_14MHZ;
    end

    // Cycle counter and strobe monitors, sampled away from the active edge
    always @(negedge CLK_14MHZ) begin
        cyc = cyc + 1;
        if (FRAME_STB) begin
            stb_cnt = stb_cnt + 1;
            stb_cyc = cyc;
        end
        if (FRAME_ERR) begin
            err_cnt = err_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK_14MHZ);
        #1;
    endtask

    function automatic logic [4:0] expKd(input logic [7:0] a);
        logic [4:0] acc;
        acc = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            if (a[r] == 1'b0) acc = acc & m_rows[r];
        end
        return acc;
    endfunction

    function automatic logic [95:0] mkFrame(input logic [7:0] f, input logic [63:0] rows, input logic [7:0] joy);
`ifdef KBD_SPI_JOY_EN
        return {16'h0, f, rows, joy};
`else
        if (joy != 8'h00) return {24'h0, f, rows};
        return {24'h0, f, rows};
`endif
    endfunction

    task automatic modelReset();
        for (int r = 0; r < 8; r++) m_rows[r] = 5'b11111;
        m_flags = 8'h00;
        m_joy   = 5'b00000;
    endtask

    task automatic modelCommit(input logic [95:0] data);
        logic [7:0] bytes [10];
        for (int b = 0; b < FB / 8; b++) bytes[b] = data[FB-1-8*b -: 8];
        m_flags = bytes[0];
        for (int r = 0; r < 8; r++) m_rows[r] = bytes[r+1][4:0];
        if (FB == 80) m_joy = bytes[9][4:0];
    endtask

    // Compare the committed state against the model for a few row selections
    task automatic verifyModel(input string tag);
        logic [7:0] sel [5];
        sel[0] = 8'hFE;
        sel[1] = 8'hFF;
        sel[2] = 8'h00;
        sel[3] = 8'h7E;
        sel[4] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            A_HI = sel[i];
            #1;
            checkOutput({tag, "_kd"}, 32'(KD), 32'(expKd(sel[i])));
        end
        checkOutput({tag, "_flags"}, 32'(FLAGS), 32'(m_flags));
`ifdef KBD_SPI_JOY_EN
        checkOutput({tag, "_joy"}, 32'(JOY), 32'(m_joy));
`endif
        A_HI = 8'hFF;
    endtask

    // Send one SPI frame at the CLK_14MHZ/8 limit; optionally end with a CLK
    // rise coincident with CS rise, or pull RESET after abortAt bits.
    task automatic applyStimulus(input string tag, input logic [95:0] data, input int nbits,
                                 input bit coincide, input int abortAt);
        int stb0;
        int err0;
        int rise_cyc;
        stb0 = stb_cnt;
        err0 = err_cnt;
        KBD_CLK = 1'b0;
        KBD_CS  = 1'b0;
        waitCycles(4);
        for (int i = 0; i < nbits; i++) begin
            if (i == abortAt) begin
                RESET = 1'b1;
                waitCycles(3);
                KBD_CS  = 1'b1;
                KBD_CLK = 1'b0;
                waitCycles(3);
                RESET = 1'b0;
                waitCycles(8);
                modelReset();
                checkOutput({tag, "_stb"}, 32'(stb_cnt - stb0), 32'd0);
                checkOutput({tag, "_err"}, 32'(err_cnt - err0), 32'd0);
                verifyModel(tag);
                return;
            end
            KBD_CLK = 1'b0;
            KBD_DI  = data[nbits-1-i];
            waitCycles(4);
            KBD_CLK = 1'b1;
            waitCycles(4);
        end
        KBD_CLK = 1'b0;
        KBD_DI  = $urandom_range(0, 1) != 0;
        waitCycles(4);
        if (coincide) KBD_CLK = 1'b1;
        KBD_CS   = 1'b1;
        rise_cyc = cyc;
        waitCycles(4);
        KBD_CLK = 1'b0;
        waitCycles(6);
        if (nbits == FB) begin
            modelCommit(data);
            checkOutput({tag, "_stb"}, 32'(stb_cnt - stb0), 32'd1);
            checkOutput({tag, "_err"}, 32'(err_cnt - err0), 32'd0);
            checkOutput({tag, "_lat"}, 32'(stb_cyc - rise_cyc), 32'd3);
        end else begin
            checkOutput({tag, "_stb"}, 32'(stb_cnt - stb0), 32'd0);
            checkOutput({tag, "_err"}, 32'(err_cnt - err0), 32'd1);
        end
        verifyModel(tag);
    endtask

    initial begin
        logic [95:0] frm;
        int          len;
        RESET   = 1'b1;
        KBD_CS  = 1'b1;
        KBD_CLK = 1'b0;
        KBD_DI  = 1'b1;
        A_HI    = 8'hFF;
        modelReset();
        waitCycles(5);
        RESET = 1'b0;
        waitCycles(4);

        $display("[TB] reset state");
        A_HI = 8'hFE;
        #1;
        checkOutput("rst_kd", 32'(KD), 32'h1F);
        checkOutput("rst_flags", 32'(FLAGS), 32'h00);
        checkOutput("rst_pulses", 32'(stb_cnt + err_cnt), 32'd0);
        verifyModel("rst");

        $display("[TB] directed frames");
        frm = mkFrame(8'h02, {8'h1E, {7{8'hFF}}}, 8'h00);
        applyStimulus("caps", frm, FB, 1'b0, -1);
        A_HI = 8'hFE;
        #1;
        checkOutput("caps_kd_fe", 32'(KD), 32'h1E);
        A_HI = 8'hFD;
        #1;
        checkOutput("caps_kd_fd", 32'(KD), 32'h1F);
        checkOutput("caps_flags", 32'(FLAGS), 32'h02);

        frm = mkFrame(8'h01, {8'h1E, {6{8'hFF}}, 8'h1D}, 8'h00);
        applyStimulus("multi", frm, FB, 1'b0, -1);
        A_HI = 8'h7E;
        #1;
        checkOutput("multi_kd_7e", 32'(KD), 32'h1C);
        A_HI = 8'h00;
        #1;
        checkOutput("multi_kd_00", 32'(KD), 32'h1C);

        frm = {$urandom, $urandom, $urandom};
        applyStimulus("short", frm, FB - 1, 1'b0, -1);
        applyStimulus("long", frm, FB + 1, 1'b0, -1);

        applyStimulus("rst40", frm, FB, 1'b0, 40);
        frm = mkFrame(8'h04, {8'hFF, 8'h0F, {6{8'hE7}}}, 8'h00);
        applyStimulus("after_rst", frm, FB, 1'b0, -1);

        frm = mkFrame(8'h03, {8'h15, 8'h0A, 8'h1B, 8'h17, 8'h1F, 8'h00, 8'h11, 8'h0E}, 8'h00);
        applyStimulus("coincide", frm, FB, 1'b1, -1);

        frm = {16'h0, 8'h00, {8{8'hFF}}, 8'h11};
        applyStimulus("joy80", frm, 80, 1'b0, -1);
`ifdef KBD_SPI_JOY_EN
        checkOutput("joy80_value", 32'(JOY), 32'h11);
`endif

        $display("[TB] random frames");
        for (int n = 0; n < 12; n++) begin
            frm = {$urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       len = FB - int'($urandom_range(1, 12));
                1:       len = FB + int'($urandom_range(1, 4));
                default: len = FB;
            endcase
            applyStimulus("rand", frm, len, $urandom_range(0, 1) != 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
